mouse_axis_emu: RTL
===================

MOUSE_AXIS_EMU -- requirements
Module: mouse_axis_emu

Interface
REQ-001 SHALL have parameter W, default 8, signed analog axis width (4..12).
REQ-002 SHALL have parameter STEP_MAX, default 10, maximum per-event axis step magnitude (1..2^(W-1)-1).
REQ-003 SHALL have parameter DECAY_PERIOD, default 65536, clocks between spring-mode recenter ticks (>=2).
REQ-004 SHALL have parameter Y_INVERT, default 1; when 1, the mouse Y delta is negated before use.
REQ-005 SHALL have ports: CLK input 1, system clock; RESET_N input 1, reset (one clock; reset is asynchronous and active-low).
REQ-006 SHALL have ps2_mouse input 25: [24] event toggle strobe, [5]/[4] Y/X sign, [23:16] Y delta, [15:8] X delta, [1:0] buttons.
REQ-007 SHALL have joya input 2*W: real analog stick, [W-1:0] X, [2W-1:W] Y, signed.
REQ-008 SHALL have joy_in input 16: digital joystick/buttons.
REQ-009 SHALL have cpu_halt input 1, which forces exit from emulation.
REQ-010 SHALL have mode input 1: 0 = absolute accumulate, 1 = spring (auto-recenter).
REQ-011 SHALL have sens input 2: right-shift applied to mouse deltas.
REQ-012 SHALL have outputs: ax output W and ay output W (signed axis values), joy_out output 16 (digital word), emu_active output 1 (mouse emulation in control).

Function
REQ-013 SHALL form 9-bit signed deltas dx={ps2_mouse[4],ps2_mouse[15:8]} and dy={ps2_mouse[5],ps2_mouse[23:16]}; with Y_INVERT=1, dy is negated, saturated to 9 bits.
REQ-014 SHALL detect a mouse event when ps2_mouse[24] differs from its registered copy; in the first clock after RESET_N deasserts, it SHALL only capture the copy, with no event.
REQ-015 SHALL arithmetically right-shift each delta by sens (rounding toward minus infinity), then clamp it to [-STEP_MAX, +STEP_MAX] in pipeline stage 1.
REQ-016 SHALL in stage 2 add the clamped step to the accumulator in W+1 bits and saturate to [-2^(W-1), 2^(W-1)-1].
REQ-017 SHALL set emu_active at the stage-2 write.
REQ-018 SHALL update ax/ay exactly 2 rising edges after the edge at which the toggle is first sampled.
REQ-019 SHALL accept back-to-back events on consecutive clocks, each applied in order with no loss.
REQ-020 SHALL, when joya is nonzero or cpu_halt=1, clear emu_active and the accumulators and flush both pipeline stages on that edge; clear SHALL have priority over a simultaneous stage-2 write.
REQ-021 SHALL output ax/ay as the accumulators when emu_active=1, and as joya X/Y otherwise.
REQ-022 SHALL output joy_out as {joy_in[15:6], ps2_mouse[1:0], joy_in[3:0]} when emu_active=1, and as joy_in otherwise; this path is combinational.
REQ-023 SHALL, in spring mode with emu_active=1, run a free counter 0..DECAY_PERIOD-1; at terminal count, each nonzero accumulator SHALL move 1 toward 0.
REQ-024 SHALL skip the decay for both axes when a decay tick coincides with a stage-2 write; the counter SHALL still wrap.
REQ-025 SHALL hold the decay counter at 0 when mode=0 or emu_active=0.
REQ-026 SHALL keep the accumulators when mode changes; decay applies from the next terminal count.

Reset
REQ-027 SHALL, while RESET_N=0, asynchronously force accumulators=0, emu_active=0, pipeline valid flags=0, decay counter=0 and strobe copy=0, so that ax/ay equal joya and joy_out equals joy_in.
REQ-028 SHALL, on reset asserted mid-pipeline, discard in-flight events with no output update after release.

Verification
REQ-029 SHALL cover: W=8, sens=0, mode=0, toggle strobe with X delta +5 -> ax=+5 two edges later, emu_active=1, ay=0.
REQ-030 SHALL cover: X delta +100 (sens=0) -> ax step +10 only; 13 such events -> ax saturates at +127, never wraps.
REQ-031 SHALL cover: Y delta +3, Y_INVERT=1 -> ay=-3; sens=2 with X delta -1 -> step -1 (floor), X delta +3 -> step 0.
REQ-032 SHALL cover: emu active, ax=+40, joya=16'h0001 on the same clock as a stage-2 write -> ax/ay=joya, emu_active=0, accumulators 0.
REQ-033 SHALL cover: mode=1, DECAY_PERIOD=4, ax=+3, ay=-2 -> after 3 ticks ax=0, ay=0; a tick coinciding with an event applies the event only.
REQ-034 SHALL cover: RESET_N held low with ps2_mouse[24]=1, then released -> no event, ax=joya X, emu_active=0.

Source files
------------

// File: rtl/mouse_axis_emu_if.sv
// Signal bundle between a PS/2 mouse / analog joystick front end and the
// mouse-to-analog-axis emulator.
interface mouse_axis_emu_if #(
    parameter int W = 8
);
    logic [24:0]         ps2_mouse;
    logic [2*W-1:0]      joya;
    logic [15:0]         joy_in;
    logic                cpu_halt;
    logic                mode;
    logic [1:0]          sens;
    logic signed [W-1:0] ax;
    logic signed [W-1:0] ay;
    logic [15:0]         joy_out;
    logic                emu_active;

    modport master (
        output ps2_mouse, joya, joy_in, cpu_halt, mode, sens,
        input  ax, ay, joy_out, emu_active
    );

    modport slave (
        input  ps2_mouse, joya, joy_in, cpu_halt, mode, sens,
        output ax, ay, joy_out, emu_active
    );
endinterface

// File: rtl/mouse_axis_emu.sv
// Turns PS/2 mouse motion into a signed analog stick position, with an
// optional spring mode that drifts the stick back to centre.
module mouse_axis_emu #(
    parameter int W            = 8,
    parameter int STEP_MAX     = 10,
    parameter int DECAY_PERIOD = 65536,
    parameter int Y_INVERT     = 1
) (
    input logic             CLK,
    input logic             RESET_N,
    mouse_axis_emu_if.slave bus
);
    localparam int CW = $clog2(DECAY_PERIOD);
    localparam logic [CW-1:0] DCNT_LAST = CW'(DECAY_PERIOD - 1);

    function automatic logic signed [8:0] neg_sat9(input logic signed [8:0] d);
        if (d == 9'sh100) return 9'sd255;
        return -d;
    endfunction

    function automatic logic signed [W-1:0] clamp_step(input logic signed [8:0] d,
                                                       input logic [1:0] sh);
        logic signed [8:0] s;
        int v;
        s = d >>> sh;
        v = int'(s);
        if (v > STEP_MAX)       v = STEP_MAX;
        else if (v < -STEP_MAX) v = -STEP_MAX;
        return W'(v);
    endfunction

    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic signed [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1]) return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return s[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] toward_zero(input logic signed [W-1:0] a);
        if (a[W-1])    return a + W'(1);
        if (a != '0)   return a - W'(1);
        return a;
    endfunction

    logic                tog_q, armed_q;
    logic                vld_p0, vld_p1;
    logic signed [8:0]   dx_p0, dy_p0;
    logic signed [W-1:0] stx_p1, sty_p1;
    logic signed [W-1:0] acc_x, acc_y;
    logic                emu_active_q;
    logic [CW-1:0]       dcnt;

    logic signed [8:0] dx_raw, dy_raw;
    logic              evt, clr, tick;

    assign dx_raw = {bus.ps2_mouse[4], bus.ps2_mouse[15:8]};
    assign dy_raw = {bus.ps2_mouse[5], bus.ps2_mouse[23:16]};
    // armed_q keeps the first edge after reset a pure capture of the strobe
    assign evt    = armed_q && (bus.ps2_mouse[24] != tog_q);
    assign clr    = (bus.joya != '0) || bus.cpu_halt;
    assign tick   = bus.mode && emu_active_q && (dcnt == DCNT_LAST);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tog_q        <= 1'b0;
            armed_q      <= 1'b0;
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            acc_x        <= '0;
            acc_y        <= '0;
            emu_active_q <= 1'b0;
            dcnt         <= '0;
        end else begin
            tog_q   <= bus.ps2_mouse[24];
            armed_q <= 1'b1;
            vld_p0  <= evt && !clr;
            vld_p1  <= vld_p0 && !clr;
            if (clr) begin
                acc_x        <= '0;
                acc_y        <= '0;
                emu_active_q <= 1'b0;
                dcnt         <= '0;
            end else begin
                if (vld_p1) begin
                    acc_x        <= sat_add(acc_x, stx_p1);
                    acc_y        <= sat_add(acc_y, sty_p1);
                    emu_active_q <= 1'b1;
                end else if (tick) begin
                    acc_x <= toward_zero(acc_x);
                    acc_y <= toward_zero(acc_y);
                end
                if (bus.mode && emu_active_q)
                    dcnt <= (dcnt == DCNT_LAST) ? '0 : dcnt + CW'(1);
                else
                    dcnt <= '0;
            end
        end
    end

    // ---- stage 0 -> 1: capture deltas, then shift and clamp ----
    always_ff @(posedge CLK) begin
        dx_p0  <= dx_raw;
        dy_p0  <= (Y_INVERT != 0) ? neg_sat9(dy_raw) : dy_raw;
        stx_p1 <= clamp_step(dx_p0, bus.sens);
        sty_p1 <= clamp_step(dy_p0, bus.sens);
    end

    assign bus.ax         = emu_active_q ? acc_x : $signed(bus.joya[W-1:0]);
    assign bus.ay         = emu_active_q ? acc_y : $signed(bus.joya[2*W-1:W]);
    assign bus.joy_out    = emu_active_q ? {bus.joy_in[15:6], bus.ps2_mouse[1:0], bus.joy_in[3:0]}
                                         : bus.joy_in;
    assign bus.emu_active = emu_active_q;

    // ps2 status bits that carry no axis information
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.ps2_mouse[7:6], bus.ps2_mouse[3:2]};
endmodule
